sd_cmd_rsp_rx: RTL and testbench

- Receive side of the SD CMD line. Captures card responses (R1/R1b/R3/R6/R7 as 48-bit, R2 as 136-bit) after the command packet is transmitted from the packet ROM.
- Checks start, transmission and end bits and CRC7. Extracts the index, argument and long-response payload.
- Sits beside the CMD transmitter in the SD controller. The init state machine arms it after each command's `tcvcptdone` and advances on `rsp_done`.

---
 rtl/sd_pkg.sv | 44 ++++
 rtl/sd_crc7.sv | 34 +++
 rtl/sd_cmd_rsp_rx.sv | 160 ++++++++++++++++
 tb/tb_sd_cmd_rsp_rx.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// -----------------------------------------------------------------------------
// sd_pkg
// Shared definitions for the SD CMD-line blocks.
// Contents:
//   rx_state_t           receiver FSM states
//   SHORT_BITS/LONG_BITS frame lengths (R1/R1b/R3/R6/R7 and R2)
//   CRC7_POLY            x^7 + x^3 + 1 without the implicit x^7 term
//   field offsets        bit positions in card numbering (bit 0 = end bit)
//   crc7_next()          one serial CRC7 step, shared by transmitter and receiver
// -----------------------------------------------------------------------------
package sd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_START = 2'd1,
        ST_SHIFT      = 2'd2,
        ST_CHECK      = 2'd3
    } rx_state_t;

    localparam int SHORT_BITS = 48;
    localparam int LONG_BITS  = 136;

    localparam logic [6:0] CRC7_POLY = 7'h09;

    // Field positions, card numbering (MSB transmitted first, bit 0 = end bit).
    localparam int SHORT_TX_BIT = 46;
    localparam int LONG_TX_BIT  = 134;
    localparam int IDX_LSB      = 40;
    localparam int LONG_IDX_LSB = 128;
    localparam int ARG_LSB      = 8;
    localparam int CRC_LSB      = 1;

    // CRC7 coverage, in transmission order (bit 0 = start bit).
    localparam int SHORT_CRC_LAST = 39;
    localparam int LONG_CRC_FIRST = 8;
    localparam int LONG_CRC_LAST  = 127;

    function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// -----------------------------------------------------------------------------
// sd_crc7
// Serial CRC7 (G = x^7 + x^3 + 1), one bit per clock, MSB first.
// Ports:
//   clk    clock
//   reset  asynchronous active-low reset
//   clr    synchronous clear (wins over en)
//   en     fold din into the CRC this cycle
//   din    serial data bit
//   crc    current CRC remainder
// -----------------------------------------------------------------------------
module sd_crc7 (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);
    import sd_pkg::*;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            crc <= 7'h00;
        end else if (clr) begin
            crc <= 7'h00;
        end else if (en) begin
            crc <= crc7_next(crc, din);
        end
    end

endmodule

// File: rtl/sd_cmd_rsp_rx.sv
// -----------------------------------------------------------------------------
// sd_cmd_rsp_rx
// Receive side of the SD CMD line: waits for a start bit after arm, shifts in
// a 48-bit or 136-bit response, checks transmission/end bits and CRC7, and
// presents index, argument and R2 payload with a one-cycle done pulse.
// Ports:
//   clk, reset        clock; asynchronous active-low reset
//   cmd_in            synchronised CMD line (idles high)
//   rsp_arm           one-cycle pulse starting a reception (ignored when busy)
//   rsp_long          136-bit R2 frame, sampled with rsp_arm
//   rsp_nocrc         skip the CRC compare (R3), sampled with rsp_arm
//   rsp_busy          high from arm until done
//   rsp_done          one-cycle pulse at frame end or timeout
//   rsp_timeout       no start bit within NCR_MAX cycles (valid with done)
//   rsp_crc_err       CRC7 mismatch (valid with done)
//   rsp_frm_err       transmission bit != 0 or end bit != 1 (valid with done)
//   rsp_index         command index field (6'h3F for R2/R3)
//   rsp_arg           short-frame bits [39:8]
//   rsp_lng           R2 bits [127:1], bit 0 forced 0
// -----------------------------------------------------------------------------
module sd_cmd_rsp_rx #(
    parameter int NCR_MAX    = 64,
    parameter int LONG_BITS  = sd_pkg::LONG_BITS,
    parameter int SHORT_BITS = sd_pkg::SHORT_BITS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_in,
    input  logic         rsp_arm,
    input  logic         rsp_long,
    input  logic         rsp_nocrc,
    output logic         rsp_busy,
    output logic         rsp_done,
    output logic         rsp_timeout,
    output logic         rsp_crc_err,
    output logic         rsp_frm_err,
    output logic [5:0]   rsp_index,
    output logic [31:0]  rsp_arg,
    output logic [127:0] rsp_lng
);
    import sd_pkg::*;

    localparam int WAIT_W = $clog2(NCR_MAX + 1);

    rx_state_t          state;
    logic               long_q;
    logic               nocrc_q;
    logic [7:0]         bit_cnt;
    logic [WAIT_W-1:0]  wait_cnt;
    // The start bit is never needed once the frame is complete, so the
    // register is one bit short of a long frame; it simply shifts out.
    logic [LONG_BITS-2:0] sr;
    logic [6:0]         crc;

    logic       crc_clr;
    logic       crc_en;
    logic       in_window;
    logic       last_bit;
    logic       rx_tx_bit;
    logic [5:0] rx_index;
    logic [6:0] rx_crc;

    // NOTE: every signal assigned here gets a value before any condition,
    // otherwise the tool infers a latch to hold it.
    always_comb begin
        crc_clr   = (state == ST_WAIT_START) && !cmd_in;
        in_window = long_q ? (bit_cnt >= 8'(LONG_CRC_FIRST) && bit_cnt <= 8'(LONG_CRC_LAST))
                           : (bit_cnt <= 8'(SHORT_CRC_LAST));
        crc_en    = (state == ST_SHIFT) && in_window;
        last_bit  = bit_cnt == (long_q ? 8'(LONG_BITS - 1) : 8'(SHORT_BITS - 1));
        rx_tx_bit = long_q ? sr[LONG_TX_BIT] : sr[SHORT_TX_BIT];
        rx_index  = long_q ? sr[LONG_IDX_LSB +: 6] : sr[IDX_LSB +: 6];
        rx_crc    = sr[CRC_LSB +: 7];
    end

    sd_crc7 u_crc7 (
        .clk   (clk),
        .reset (reset),
        .clr   (crc_clr),
        .en    (crc_en),
        .din   (cmd_in),
        .crc   (crc)
    );

    assign rsp_busy = (state != ST_IDLE);

    // NOTE: the frame shift register is reset like the control state; it is
    // flop-based, and a defined value keeps outputs clean after an aborted frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            long_q      <= 1'b0;
            nocrc_q     <= 1'b0;
            bit_cnt     <= 8'd0;
            wait_cnt    <= '0;
            sr          <= '0;
            rsp_done    <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_crc_err <= 1'b0;
            rsp_frm_err <= 1'b0;
            rsp_index   <= 6'd0;
            rsp_arg     <= 32'd0;
            rsp_lng     <= 128'd0;
        end else begin
            rsp_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rsp_arm) begin
                        long_q      <= rsp_long;
                        nocrc_q     <= rsp_nocrc;
                        wait_cnt    <= '0;
                        sr          <= '0;
                        rsp_timeout <= 1'b0;
                        rsp_crc_err <= 1'b0;
                        rsp_frm_err <= 1'b0;
                        rsp_index   <= 6'd0;
                        rsp_arg     <= 32'd0;
                        rsp_lng     <= 128'd0;
                        state       <= ST_WAIT_START;
                    end
                end
                ST_WAIT_START: begin
                    // Start bit is tested first so it wins on the last wait cycle.
                    if (!cmd_in) begin
                        bit_cnt <= 8'd1;
                        sr      <= {sr[LONG_BITS-3:0], cmd_in};
                        state   <= ST_SHIFT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt == WAIT_W'(NCR_MAX - 1)) begin
                            rsp_timeout <= 1'b1;
                            state       <= ST_CHECK;
                        end
                    end
                end
                ST_SHIFT: begin
                    sr      <= {sr[LONG_BITS-3:0], cmd_in};
                    bit_cnt <= bit_cnt + 8'd1;
                    if (last_bit) begin
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    rsp_crc_err <= !nocrc_q && !rsp_timeout && (crc != rx_crc);
                    rsp_frm_err <= !rsp_timeout && (rx_tx_bit || !sr[0]);
                    rsp_index   <= rx_index;
                    if (long_q) begin
                        rsp_lng <= {sr[127:1], 1'b0};
                    end else begin
                        rsp_arg <= sr[ARG_LSB +: 32];
                    end
                    rsp_done <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_rsp_rx.sv
// -----------------------------------------------------------------------------
// tb_sd_cmd_rsp_rx
// Directed bench for sd_cmd_rsp_rx. Expected responses are queued when a frame
// (or an arm that should time out) is driven and compared when rsp_done pulses.
// -----------------------------------------------------------------------------
module tb_sd_cmd_rsp_rx;

    typedef struct {
        string        tag;
        int           exp_cyc;
        logic         timeout;
        logic         crc_err;
        logic         frm_err;
        logic [5:0]   index;
        logic [31:0]  arg;
        logic [127:0] lng;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         cmd_in;
    logic         rsp_arm;
    logic         rsp_long;
    logic         rsp_nocrc;
    logic         rsp_busy;
    logic         rsp_done;
    logic         rsp_timeout;
    logic         rsp_crc_err;
    logic         rsp_frm_err;
    logic [5:0]   rsp_index;
    logic [31:0]  rsp_arg;
    logic [127:0] rsp_lng;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    sd_cmd_rsp_rx dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_in      (cmd_in),
        .rsp_arm     (rsp_arm),
        .rsp_long    (rsp_long),
        .rsp_nocrc   (rsp_nocrc),
        .rsp_busy    (rsp_busy),
        .rsp_done    (rsp_done),
        .rsp_timeout (rsp_timeout),
        .rsp_crc_err (rsp_crc_err),
        .rsp_frm_err (rsp_frm_err),
        .rsp_index   (rsp_index),
        .rsp_arg     (rsp_arg),
        .rsp_lng     (rsp_lng)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // CRC7 by long division of data * x^7 by x^7 + x^3 + 1 (8'h89).
    function automatic logic [6:0] crc7_div(input logic [119:0] data);
        logic [126:0] r;
        r = {data, 7'b0};
        for (int i = 126; i >= 7; i--) begin
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        end
        return r[6:0];
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rsp_done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", {127'd0, rsp_done}, 128'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.tag, "_cyc"},     128'(cyc),         128'(e.exp_cyc));
                check({e.tag, "_busy"},    {127'd0, rsp_busy}, 128'd0);
                check({e.tag, "_timeout"}, {127'd0, rsp_timeout}, {127'd0, e.timeout});
                check({e.tag, "_crc"},     {127'd0, rsp_crc_err}, {127'd0, e.crc_err});
                check({e.tag, "_frm"},     {127'd0, rsp_frm_err}, {127'd0, e.frm_err});
                check({e.tag, "_index"},   {122'd0, rsp_index},   {122'd0, e.index});
                check({e.tag, "_arg"},     {96'd0, rsp_arg},      {96'd0, e.arg});
                check({e.tag, "_lng"},     rsp_lng,               e.lng);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            cmd_in = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic arm(input logic lng, input logic nocrc, output int arm_cyc);
        rsp_arm   = 1'b1;
        rsp_long  = lng;
        rsp_nocrc = nocrc;
        arm_cyc   = cyc;
        @(posedge clk); #1;
        rsp_arm   = 1'b0;
        rsp_long  = 1'b0;
        rsp_nocrc = 1'b0;
        check("busy_after_arm", {127'd0, rsp_busy}, 128'd1);
    endtask

    task automatic send_frame(input logic [135:0] f, input int len, output int end_cyc);
        end_cyc = 0;
        for (int i = len - 1; i >= 0; i--) begin
            cmd_in = f[i];
            end_cyc = cyc;
            @(posedge clk); #1;
        end
        cmd_in = 1'b1;
    endtask

    task automatic push(input string tag, input int exp_cyc, input logic t, input logic c,
                        input logic fe, input logic [5:0] idx, input logic [31:0] a,
                        input logic [127:0] l);
        exp_t e;
        e.tag = tag; e.exp_cyc = exp_cyc; e.timeout = t; e.crc_err = c;
        e.frm_err = fe; e.index = idx; e.arg = a; e.lng = l;
        sb.push_back(e);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_drain"}, 128'(sb.size()), 128'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_done"},  {127'd0, rsp_done},    128'd0);
        check({tag, "_busy"},  {127'd0, rsp_busy},    128'd0);
        check({tag, "_tmo"},   {127'd0, rsp_timeout}, 128'd0);
        check({tag, "_crc"},   {127'd0, rsp_crc_err}, 128'd0);
        check({tag, "_frm"},   {127'd0, rsp_frm_err}, 128'd0);
        check({tag, "_index"}, {122'd0, rsp_index},   128'd0);
        check({tag, "_arg"},   {96'd0, rsp_arg},      128'd0);
        check({tag, "_lng"},   rsp_lng,               128'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int           a;
        int           e;
        logic [127:0] cid;
        logic [135:0] lframe;

        reset = 1'b0; cmd_in = 1'b1; rsp_arm = 1'b0; rsp_long = 1'b0; rsp_nocrc = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b1;
        @(posedge clk); #1;

        // R7 echo, CRC checked.
        arm(1'b0, 1'b0, a);
        idle(5);
        send_frame({88'd0, 48'h08_0000_01AA_13}, 48, e);
        push("r7", e + 2, 1'b0, 1'b0, 1'b0, 6'h08, 32'h0000_01AA, 128'd0);
        drain("r7");

        // R3 with CRC skipped; a stray arm while busy must be ignored.
        arm(1'b0, 1'b1, a);
        rsp_arm = 1'b1; rsp_long = 1'b1;
        idle(1);
        rsp_arm = 1'b0; rsp_long = 1'b0;
        idle(2);
        send_frame({88'd0, 48'h3F_00FF_8000_FF}, 48, e);
        push("r3", e + 2, 1'b0, 1'b0, 1'b0, 6'h3F, 32'h00FF_8000, 128'd0);
        drain("r3");

        // R7 with a corrupted argument byte.
        arm(1'b0, 1'b0, a);
        idle(2);
        send_frame({88'd0, 48'h08_0000_01AB_13}, 48, e);
        push("r7bad", e + 2, 1'b0, 1'b1, 1'b0, 6'h08, 32'h0000_01AB, 128'd0);
        drain("r7bad");

        // Transmission bit set, CRC otherwise consistent.
        arm(1'b0, 1'b0, a);
        idle(1);
        send_frame({88'd0, 48'h40_0000_0000_95}, 48, e);
        push("txbit", e + 2, 1'b0, 1'b0, 1'b1, 6'h00, 32'h0, 128'd0);
        drain("txbit");

        // No start bit: timeout done at arm + NCR_MAX + 2.
        arm(1'b0, 1'b0, a);
        push("tmo", a + 66, 1'b1, 1'b0, 1'b0, 6'h00, 32'h0, 128'd0);
        drain("tmo");
        idle(3);
        check("tmo_hold", {127'd0, rsp_timeout}, 128'd1);

        // Start bit on the last wait cycle wins over the timeout.
        arm(1'b0, 1'b0, a);
        idle(63);
        send_frame({88'd0, 48'h08_0000_01AA_13}, 48, e);
        push("late_start", e + 2, 1'b0, 1'b0, 1'b0, 6'h08, 32'h0000_01AA, 128'd0);
        drain("late_start");

        // R2 interrupted by reset at bit 70: everything clears, no done.
        cid        = 128'h0353_4453_4330_3847_8012_3456_7801_2345;
        cid[7:1]   = crc7_div(cid[127:8]);
        cid[0]     = 1'b1;
        lframe     = {2'b00, 6'h3F, cid[127:1], 1'b1};
        arm(1'b1, 1'b0, a);
        idle(4);
        for (int i = 135; i > 65; i--) begin
            cmd_in = lframe[i];
            @(posedge clk); #1;
        end
        reset = 1'b0;
        #1;
        check_all_zero("abort");
        @(posedge clk); #1;
        reset  = 1'b1;
        cmd_in = 1'b1;
        idle(10);
        check("abort_idle_busy", {127'd0, rsp_busy}, 128'd0);

        // Resend the full R2.
        arm(1'b1, 1'b0, a);
        idle(2);
        send_frame(lframe, 136, e);
        push("r2", e + 2, 1'b0, 1'b0, 1'b0, 6'h3F, 32'h0, {cid[127:1], 1'b0});
        drain("r2");

        idle(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
